// File: rtl/mdc_pkg.sv
// Shared constants for the GCD (MDC) request front-end and the core it drives.
package mdc_pkg;

  // Operand/result width shared with the GCD core.
  localparam int MDC_WIDTH = 8;

  // Front-end controller state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_RESP  = 3'd3;
  localparam logic [2:0] ST_ABORT = 3'd4;

endpackage

// File: rtl/mdc_watchdog.sv
// Run-length counter for the GCD front-end: counts cycles while enabled,
// clears on request, saturates at all-ones, flags the last allowed cycle.
module mdc_watchdog
  import mdc_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Counter: clear has priority over enable; holds once it reaches all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  // Terminal count: this RUN cycle is the last one the budget allows.
  assign o_tc  = (r_cnt == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/mdc_req_ctrl.sv
// Request/response front-end for the GCD core: takes one operand pair,
// holds start to the core until done, then returns result and cycle count.
// A watchdog aborts over-long runs with a one-cycle core reset.
module mdc_req_ctrl
  import mdc_pkg::*;
#(
  parameter int WIDTH      = MDC_WIDTH,
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_start,
  output logic             core_rst,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [CNT_W-1:0] out_cycles,
  output logic             out_timeout
);

  logic [2:0]       r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_core_a;
  logic [WIDTH-1:0] r_core_b;
  logic             r_core_start;
  logic             r_core_rst;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_gcd;
  logic [CNT_W-1:0] r_out_cycles;
  logic             r_out_timeout;

  logic             w_accept;
  logic             w_resp_hs;
  logic             w_run;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;

  assign w_accept  = in_valid && r_in_ready;
  assign w_resp_hs = r_out_valid && out_ready;
  assign w_run     = (r_state == ST_RUN);

  mdc_watchdog #(
    .CNT_W      (CNT_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_wdog (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_accept),
    .i_en  (w_run),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );

  // Controller FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b1;
      r_core_a      <= '0;
      r_core_b      <= '0;
      r_core_start  <= 1'b0;
      r_core_rst    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_gcd     <= '0;
      r_out_cycles  <= '0;
      r_out_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_core_a      <= in_a;
            r_core_b      <= in_b;
            r_out_timeout <= 1'b0;
            r_in_ready    <= 1'b0;
            // start is up in the first RUN cycle
            r_core_start  <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          // done takes precedence over the budget running out
          if (core_done) begin
            r_out_gcd    <= core_result;
            r_out_cycles <= w_cnt;
            r_core_start <= 1'b0;
            r_state      <= ST_DRAIN;
          end else if (w_tc) begin
            // abort outputs are registered so they show during ABORT
            r_core_start  <= 1'b0;
            r_core_rst    <= 1'b1;
            r_out_gcd     <= '0;
            r_out_cycles  <= CNT_W'(MAX_CYCLES);
            r_out_timeout <= 1'b1;
            r_state       <= ST_ABORT;
          end
        end
        ST_DRAIN: begin
          // let the core fall back to its wait state before responding
          if (!core_done) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_ABORT: begin
          r_core_rst  <= 1'b0;
          r_out_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_resp_hs) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_in_ready   <= 1'b1;
          r_core_start <= 1'b0;
          r_core_rst   <= 1'b0;
          r_out_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign core_start  = r_core_start;
  assign core_rst    = r_core_rst;
  assign out_valid   = r_out_valid;
  assign out_gcd     = r_out_gcd;
  assign out_cycles  = r_out_cycles;
  assign out_timeout = r_out_timeout;

endmodule

// File: tb/tb_mdc_req_ctrl.sv
// Bench for mdc_req_ctrl with a behavioural Euclid core attached.
module tb_mdc_req_ctrl;

  localparam int W    = 8;
  localparam int CW   = 16;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_a, in_b;
  logic [W-1:0]  core_a, core_b;
  logic          core_start, core_rst, core_done;
  logic [W-1:0]  core_result;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_gcd;
  logic [CW-1:0] out_cycles;
  logic          out_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdc_req_ctrl #(.WIDTH(W), .CNT_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_a(core_a), .core_b(core_b), .core_start(core_start), .core_rst(core_rst),
    .core_done(core_done), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gcd(out_gcd), .out_cycles(out_cycles), .out_timeout(out_timeout)
  );

  // Behavioural core: wait for start, one Euclid step (a,b)->(b,a%b) per
  // cycle, hold done until start drops. 'stuck' masks done off.
  logic         stuck;
  logic [1:0]   cm_st;
  logic [W-1:0] cm_a, cm_b, cm_res;
  logic         cm_done;
  always @(posedge clk) begin
    if (rst || core_rst) begin
      cm_st <= 2'd0; cm_done <= 1'b0; cm_a <= '0; cm_b <= '0; cm_res <= '0;
    end else begin
      case (cm_st)
        2'd0: if (core_start) begin cm_a <= core_a; cm_b <= core_b; cm_st <= 2'd1; end
        2'd1: if (cm_b == 0) begin cm_res <= cm_a; cm_done <= 1'b1; cm_st <= 2'd2; end
              else begin cm_a <= cm_b; cm_b <= cm_a % cm_b; end
        default: if (!core_start) begin cm_done <= 1'b0; cm_st <= 2'd0; end
      endcase
    end
  end
  assign core_done   = cm_done && !stuck;
  assign core_result = cm_res;

  // Reference: GCD by plain arithmetic and the run length of the stub core
  // (one load cycle, one cycle per Euclid step, one cycle to raise done).
  function automatic int m_gcd(input int a, input int b);
    int t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction
  function automatic int m_lat(input int a, input int b);
    int t, n;
    n = 0;
    while (b != 0) begin t = a % b; a = b; b = t; n++; end
    return n + 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_rst"}, core_rst, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_core_ab"}, {core_a, core_b}, 0);
    chk({tag, "_out_gcd"}, out_gcd, 0);
    chk({tag, "_out_cycles"}, out_cycles, 0);
    chk({tag, "_out_timeout"}, out_timeout, 0);
  endtask

  // One request with out_ready high; checks operands stay put while start is up.
  task automatic run_pair(input int a, input int b, input int eg, input string nm);
    int k;
    bit held;
    k = 0;
    held = 1'b1;
    @(negedge clk);
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, in_ready, 1);
    in_valid = 1'b1; in_a = W'(a); in_b = W'(b); out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin
      if (core_start && (core_a != W'(a) || core_b != W'(b))) held = 1'b0;
      @(negedge clk); k++;
    end
    chk({nm, "_resp_seen"}, out_valid, 1);
    chk({nm, "_ops_held"}, held, 1);
    chk({nm, "_gcd"}, out_gcd, eg);
    chk({nm, "_cycles"}, out_cycles, m_lat(a, b));
    chk({nm, "_timeout"}, out_timeout, 0);
    @(negedge clk);
    chk({nm, "_idle_after"}, {out_valid, in_ready}, 2'b01);
  endtask

  // Streamed requests from sa/sb with a scoreboard; rnd jitters the handshakes.
  logic [W-1:0] sa[$], sb[$];
  task automatic stream(input bit rnd, input string nm);
    int eg[$], ec[$];
    int idx, resp, n, cyc;
    idx = 0; resp = 0; cyc = 0; n = sa.size();
    while (resp < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (idx < n) && (!rnd || $urandom_range(0, 1) == 1);
      if (idx < n) begin in_a = sa[idx]; in_b = sb[idx]; end
      out_ready = !rnd || ($urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        chk({nm, "_single_outstanding"}, eg.size(), 0);
        eg.push_back(m_gcd(int'(sa[idx]), int'(sb[idx])));
        ec.push_back(m_lat(int'(sa[idx]), int'(sb[idx])));
        idx++;
      end
      if (out_valid && out_ready) begin
        if (eg.size() == 0) chk({nm, "_unexpected_resp"}, 1, 0);
        else begin
          chk({nm, "_gcd"}, out_gcd, eg.pop_front());
          chk({nm, "_cycles"}, out_cycles, ec.pop_front());
          chk({nm, "_timeout"}, out_timeout, 0);
        end
        resp++;
      end
    end
    in_valid = 1'b0;
    chk({nm, "_all_resp"}, resp, n);
  endtask

  typedef struct {
    int a;
    int b;
    int g;
  } vec_t;

  initial begin
    vec_t vt[8];
    int starts, pulses, k;

    vt[0] = '{48, 18, 6};   vt[1] = '{7, 0, 7};     vt[2] = '{0, 5, 5};
    vt[3] = '{0, 0, 0};     vt[4] = '{12, 8, 4};    vt[5] = '{35, 14, 7};
    vt[6] = '{255, 1, 1};   vt[7] = '{233, 144, 1};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < 8; i++) run_pair(vt[i].a, vt[i].b, vt[i].g, $sformatf("vec%0d", i));

    // Backpressure: response held while out_ready is low.
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'd12; in_b = 8'd8; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 100) begin @(negedge clk); k++; end
    chk("bp_resp_seen", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {out_valid, in_ready, out_gcd}, {1'b1, 1'b0, 8'd4});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // Timeout: core never signals done.
    stuck = 1'b1;
    in_valid = 1'b1; in_a = 8'd5; in_b = 8'd3;
    @(negedge clk);
    in_valid = 1'b0;
    starts = 0; pulses = 0; k = 0;
    while (!out_valid && k < 100) begin
      if (core_start) starts++;
      if (core_rst) pulses++;
      @(negedge clk); k++;
    end
    chk("to_run_cycles", starts, MAXC);
    chk("to_rst_pulses", pulses, 1);
    chk("to_resp", {out_valid, out_timeout}, 2'b11);
    chk("to_gcd", out_gcd, 0);
    chk("to_cycles", out_cycles, MAXC);
    @(negedge clk);
    chk("to_idle_after", {out_valid, in_ready}, 2'b01);
    stuck = 1'b0;

    // Reset in the third RUN cycle.
    in_valid = 1'b1; in_a = 8'd48; in_b = 8'd18;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    run_pair(9, 6, 3, "post_rst");

    // Back-to-back with in_valid held high.
    sa = '{8'd48, 8'd35}; sb = '{8'd18, 8'd14};
    stream(1'b0, "b2b");

    // Randomised traffic.
    sa.delete(); sb.delete();
    for (int i = 0; i < 40; i++) begin
      sa.push_back(($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(0, 255)));
      sb.push_back(($urandom_range(0, 7) == 0) ? 8'd0 : W'($urandom_range(0, 255)));
    end
    stream(1'b1, "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
